// File: rtl/masked_affine_pipe_if.sv
// masked_affine_pipe_if: valid/ready stream of Boolean-shared bytes plus refresh randomness
interface masked_affine_pipe_if #(parameter int SHARES = 2) ();
  logic                      in_valid;
  logic                      in_ready;
  logic [8*SHARES-1:0]       in_shares;
  logic [8*(SHARES-1)-1:0]   r;
  logic                      out_valid;
  logic                      out_ready;
  logic [8*SHARES-1:0]       out_shares;
  logic                      busy;
  modport master (output in_valid, in_shares, r, out_ready, input in_ready, out_valid, out_shares, busy);
  modport slave  (input in_valid, in_shares, r, out_ready, output in_ready, out_valid, out_shares, busy);
endinterface

// File: rtl/masked_affine_pipe.sv
// masked_affine_pipe: share-wise AES affine map over a valid/ready register pipeline with input refresh
// Define MASKED_CLOCK_GATING_EN to load stage data only on real transfers.
module masked_affine_pipe #(
  parameter int SHARES  = 2,
  parameter int LATENCY = 2,
  parameter int MODE    = 0
) (
  input logic clk,
  input logic rst_n,
  masked_affine_pipe_if.slave bus
);
  localparam int W = 8 * SHARES;
  localparam logic [7:0] C = MODE == 0 ? 8'h63 : MODE == 1 ? 8'h05 : 8'h00;

  function automatic logic [7:0] aff(input logic [7:0] x);
    logic [7:0] b;
    for (int i = 0; i < 8; i++)
      b[i] = MODE == 0 ? x[i] ^ x[(i+4)%8] ^ x[(i+5)%8] ^ x[(i+6)%8] ^ x[(i+7)%8] :
             MODE == 1 ? x[(i+2)%8] ^ x[(i+5)%8] ^ x[(i+7)%8] : x[i];
    return b;
  endfunction

  // Linear part per share; the constant lands on share 0 only so it appears once in the unmasked value.
  function automatic logic [W-1:0] affs(input logic [W-1:0] s);
    logic [W-1:0] o;
    for (int j = 0; j < SHARES; j++) o[8*j +: 8] = aff(s[8*j +: 8]);
    o[7:0] = o[7:0] ^ C;
    return o;
  endfunction

  logic [LATENCY-1:0] v, tin, ld;
  logic [LATENCY:0]   rdy;
  logic [W-1:0]       d  [LATENCY];
  logic [W-1:0]       nd [LATENCY];
  logic [W-1:0]       rf;
  logic [7:0]         rx;

  always_comb begin
    rx = '0;
    rf = bus.in_shares;
    for (int j = 0; j < SHARES - 1; j++) begin
      rf[8*j +: 8] = rf[8*j +: 8] ^ bus.r[8*j +: 8];
      rx = rx ^ bus.r[8*j +: 8];
    end
    rf[W-8 +: 8] = rf[W-8 +: 8] ^ rx;
  end

  // A stage is ready if it or any stage downstream of it has a hole, or the sink accepts.
  always_comb begin
    rdy[LATENCY] = bus.out_ready;
    for (int k = 0; k < LATENCY; k++) begin
      rdy[k] = bus.out_ready;
      for (int j = k; j < LATENCY; j++) rdy[k] = rdy[k] | ~v[j];
    end
  end

  always_comb begin
    nd[0]  = LATENCY == 1 ? affs(rf) : rf;
    tin[0] = bus.in_valid & rdy[0];
    for (int k = 1; k < LATENCY; k++) begin
      nd[k]  = k == 1 ? affs(d[0]) : d[k-1];
      tin[k] = v[k-1] & rdy[k];
    end
`ifdef MASKED_CLOCK_GATING_EN
    ld = tin;
`else
    ld = tin | ~v;
`endif
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v <= '0;
      for (int k = 0; k < LATENCY; k++) d[k] <= '0;
    end else begin
      for (int k = 0; k < LATENCY; k++) begin
        v[k] <= tin[k] | (v[k] & ~rdy[k+1]);
        if (ld[k]) d[k] <= nd[k];
      end
    end

  assign bus.in_ready   = rdy[0];
  assign bus.out_valid  = v[LATENCY-1];
  assign bus.out_shares = d[LATENCY-1];
  assign bus.busy       = |v;
endmodule

// File: tb/tb_masked_affine_pipe.sv
// tb_masked_affine_pipe: randomized scoreboard plus directed checks of the masked affine pipeline
module tb_masked_affine_pipe;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  masked_affine_pipe_if #(.SHARES(2)) a ();
  masked_affine_pipe_if #(.SHARES(3)) b ();
  masked_affine_pipe_if #(.SHARES(4)) c ();
  masked_affine_pipe #(.SHARES(2), .LATENCY(2), .MODE(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(a));
  masked_affine_pipe #(.SHARES(3), .LATENCY(1), .MODE(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b));
  masked_affine_pipe #(.SHARES(4), .LATENCY(3), .MODE(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(c));

  int n = 0, err = 0;
  logic [7:0] q[$];
  logic acc, pop;
  logic [7:0] x;
  logic [31:0] s;
  logic [15:0] snap;
  logic [15:0] items[8];
  int idx, pops, first, last, seen;

  function automatic logic [7:0] rl(input logic [7:0] v, input int k);
    return (v << k) | (v >> (8 - k));
  endfunction

  function automatic logic [7:0] ref_map(input int mode, input logic [7:0] v);
    return mode == 0 ? (v ^ rl(v, 1) ^ rl(v, 2) ^ rl(v, 3) ^ rl(v, 4) ^ 8'h63) :
           mode == 1 ? (rl(v, 1) ^ rl(v, 3) ^ rl(v, 6) ^ 8'h05) : v;
  endfunction

  function automatic logic [7:0] xs(input logic [31:0] v);
    return v[7:0] ^ v[15:8] ^ v[23:16] ^ v[31:24];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n++;
    if (got !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    #1;
    acc = a.in_valid && a.in_ready;
    pop = a.out_valid && a.out_ready;
    if (pop) begin
      if (q.size() == 0) chk("spurious_out", 32'(a.out_shares), 32'hFFFF_FFFF);
      else chk("stream", 32'(xs(32'(a.out_shares))), 32'(q.pop_front()));
    end
    if (acc) q.push_back(ref_map(0, xs(32'(a.in_shares))));
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    a.in_valid = 0; a.in_shares = '0; a.r = '0; a.out_ready = 1;
    b.in_valid = 0; b.in_shares = '0; b.r = '0; b.out_ready = 1;
    c.in_valid = 0; c.in_shares = '0; c.r = '0; c.out_ready = 1;
    #2;
    chk("rst_valid", 32'(a.out_valid), 0);
    chk("rst_data", 32'(a.out_shares), 0);
    chk("rst_busy", 32'(a.busy), 0);
    chk("rst_ready", 32'(a.in_ready), 1);
    @(negedge clk);
    rst_n = 1;
    // zero secret, refresh with 0xA5
    a.in_valid = 1; a.in_shares = 16'h3C3C; a.r = 8'hA5;
    tick();
    chk("first_acc", 32'(acc), 1);
    a.in_valid = 0;
    chk("lat1_valid", 32'(a.out_valid), 0);
    tick();
    chk("lat2_valid", 32'(a.out_valid), 1);
    chk("zero_xor", 32'(xs(32'(a.out_shares))), 32'h63);
    chk("share1", 32'(a.out_shares[15:8]), 32'(ref_map(0, 8'h3C ^ 8'hA5) ^ 8'h63));
    chk("refreshed", 32'(a.out_shares[15:8] != 8'h3C), 1);
    a.in_valid = 1; a.in_shares = {8'h01 ^ 8'h77, 8'h77}; a.r = 8'($urandom);
    tick();
    a.in_valid = 0;
    tick();
    chk("m0_01", 32'(xs(32'(a.out_shares))), 32'h7C);
    // randomized traffic with random backpressure
    for (int t = 0; t < 400; t++) begin
      a.in_valid = ($urandom % 4) != 0;
      a.in_shares = 16'($urandom);
      a.r = 8'($urandom);
      a.out_ready = ($urandom % 3) != 0;
      tick();
    end
    a.in_valid = 0; a.out_ready = 1;
    for (int t = 0; t < 10; t++) tick();
    chk("drained", q.size(), 0);
    // fill against a stalled sink, then release
    for (int i = 0; i < 8; i++) items[i] = 16'($urandom);
    idx = 0;
    a.out_ready = 0;
    for (int t = 0; t < 6; t++) begin
      a.in_valid = 1; a.in_shares = items[idx]; a.r = 8'($urandom);
      tick();
      if (acc) idx++;
    end
    chk("bp_accepted", idx, 2);
    #1;
    chk("bp_in_ready", 32'(a.in_ready), 0);
    snap = a.out_shares;
    for (int t = 0; t < 3; t++) tick();
    chk("bp_hold", 32'(a.out_shares), 32'(snap));
    chk("bp_valid", 32'(a.out_valid), 1);
    a.out_ready = 1;
    pops = 0; first = -1; last = -1;
    for (int t = 0; t < 30 && pops < 8; t++) begin
      a.in_valid = idx < 8;
      if (idx < 8) a.in_shares = items[idx];
      a.r = 8'($urandom);
      tick();
      if (acc) idx++;
      if (pop) begin
        pops++;
        if (first < 0) first = t;
        last = t;
      end
    end
    a.in_valid = 0;
    chk("bp_pops", pops, 8);
    chk("bp_rate", last - first, 7);
    // reset with two items in flight
    a.out_ready = 0; a.in_valid = 1;
    a.in_shares = 16'($urandom); tick();
    a.in_shares = 16'($urandom); tick();
    a.in_valid = 0;
    chk("pre_rst_busy", 32'(a.busy), 1);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_valid", 32'(a.out_valid), 0);
    chk("mid_rst_data", 32'(a.out_shares), 0);
    chk("mid_rst_busy", 32'(a.busy), 0);
    chk("mid_rst_ready", 32'(a.in_ready), 1);
    q.delete();
    @(negedge clk);
    rst_n = 1; a.out_ready = 1;
    seen = 0;
    for (int t = 0; t < 8; t++) begin
      tick();
      if (pop) seen++;
    end
    chk("rst_no_out", seen, 0);
    // idle pipe with toggling, never-valid input data
    a.r = 8'h00; a.in_shares = 16'h0000;
    for (int t = 0; t < 3; t++) tick();
    snap = a.out_shares;
    a.in_shares = 16'hFFFF; tick();
    a.in_shares = 16'h0000; tick();
`ifdef MASKED_CLOCK_GATING_EN
    chk("idle_gated", 32'(a.out_shares), 32'(snap));
`else
    chk("idle_ungated", 32'(a.out_shares), 32'hFF9C);
`endif
    chk("idle_valid", 32'(a.out_valid), 0);
    // inverse affine, three shares, single stage
    for (int t = 0; t < 5; t++) begin
      x = t == 0 ? 8'h7C : 8'($urandom);
      s = $urandom;
      b.in_shares = {x ^ s[7:0] ^ s[15:8], s[15:0]};
      b.r = 16'($urandom);
      b.in_valid = 1;
      #1 chk("m1_ready", 32'(b.in_ready), 1);
      @(negedge clk);
      b.in_valid = 0;
      #1;
      chk("m1_valid", 32'(b.out_valid), 1);
      chk("m1_value", 32'(xs(32'(b.out_shares))), t == 0 ? 32'h01 : 32'(ref_map(1, x)));
      @(negedge clk);
    end
    // identity, four shares, three stages
    for (int t = 0; t < 5; t++) begin
      x = t == 0 ? 8'h5A : 8'($urandom);
      s = $urandom;
      c.in_shares = {x ^ s[7:0] ^ s[15:8] ^ s[23:16], s[23:0]};
      c.r = 24'($urandom);
      c.in_valid = 1;
      @(negedge clk);
      c.in_valid = 0;
      @(negedge clk);
      #1 chk("m2_early", 32'(c.out_valid), 0);
      @(negedge clk);
      #1;
      chk("m2_valid", 32'(c.out_valid), 1);
      chk("m2_value", 32'(xs(c.out_shares)), t == 0 ? 32'h5A : 32'(ref_map(2, x)));
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n, err);
    $finish;
  end
endmodule
